// File: rtl/b_resp_merge.sv
// rtl/b_resp_merge.sv - merges slave sub-burst B responses into one master B response
module b_resp_merge #(
    parameter int BID_WIDTH      = 3,
    parameter int BRESP_WIDTH    = 2,
    parameter int SUB_XFER_CNT   = 3,
    parameter int RESP_ARR_WIDTH = 9,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                  aclk,
    input  logic                                  arst,
    input  logic                                  aw_push,
    input  logic [BID_WIDTH-1:0]                  aw_id,
    input  logic [$clog2(SUB_XFER_CNT+1)-1:0]     aw_sub_cnt,
    output logic                                  aw_ready,
    input  logic                                  s_b_handshake,
    input  logic [BRESP_WIDTH-1:0]                s_bresp,
    input  logic                                  rd_ready,
    output logic                                  rd_valid,
    output logic [RESP_ARR_WIDTH-1:0]             resp,
    output logic                                  err_unexp
);

    localparam int CNT_W  = $clog2(SUB_XFER_CNT + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_SUB  = CNT_W'(SUB_XFER_CNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE
    } state_t;

    state_t state, state_nxt;

    logic [BID_WIDTH-1:0]   id_mem  [FIFO_DEPTH];
    logic [CNT_W-1:0]       cnt_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [OCC_W-1:0]       occ, occ_nxt;

    logic [CNT_W-1:0]       sub_ctr;
    logic [CNT_W-1:0]       sub_inc;
    logic [BRESP_WIDTH-1:0] acc;
    logic [BRESP_WIDTH-1:0] merged;
    logic [CNT_W-1:0]       sub_norm;
    logic [BID_WIDTH-1:0]   head_id;
    logic [CNT_W-1:0]       head_cnt;
    logic                   pop;
    logic                   push_ok;
    logic                   push_drop;
    logic                   hs_collect;
    logic                   last_sub;
    logic                   hs_unexp;

    // Severity rank: DECERR > SLVERR > OKAY > EXOKAY.
    function automatic logic [1:0] bresp_rank(input logic [BRESP_WIDTH-1:0] r);
        logic [1:0] rk;
        case (r[1:0])
            2'b11:   rk = 2'd3;
            2'b10:   rk = 2'd2;
            2'b00:   rk = 2'd1;
            default: rk = 2'd0;
        endcase
        return rk;
    endfunction

    function automatic logic [BRESP_WIDTH-1:0] merge_bresp(
        input logic [BRESP_WIDTH-1:0] a,
        input logic [BRESP_WIDTH-1:0] b
    );
        return (bresp_rank(a) >= bresp_rank(b)) ? a : b;
    endfunction

    function automatic logic [RESP_ARR_WIDTH-1:0] pack_resp(
        input logic [BID_WIDTH-1:0]   id,
        input logic [BRESP_WIDTH-1:0] br
    );
        logic [RESP_ARR_WIDTH-1:0] v;
        v                                  = '0;
        v[0]                               = 1'b1;
        v[BRESP_WIDTH:1]                   = br;
        v[RESP_ARR_WIDTH-1 -: BID_WIDTH]   = id;
        return v;
    endfunction

    assign aw_ready  = (occ != FULL_OCC);
    assign pop       = (state == S_ISSUE) && rd_ready;
    assign rd_valid  = pop;
    // A push that coincides with a pop always fits, even when full.
    assign push_ok   = aw_push && (aw_ready || pop);
    assign push_drop = aw_push && !aw_ready && !pop;

    assign head_id    = id_mem[rd_ptr];
    assign head_cnt   = cnt_mem[rd_ptr];
    assign hs_collect = s_b_handshake && (state == S_COLLECT);
    assign hs_unexp   = s_b_handshake && (state != S_COLLECT);
    assign sub_inc    = sub_ctr + CNT_W'(1);
    assign last_sub   = (sub_inc == head_cnt);
    assign merged     = (sub_ctr == '0) ? s_bresp : merge_bresp(acc, s_bresp);

    always_comb begin
        sub_norm = aw_sub_cnt;
        if (aw_sub_cnt == '0) begin
            sub_norm = CNT_W'(1);
        end else if (aw_sub_cnt >= MAX_SUB) begin
            sub_norm = MAX_SUB;
        end
    end

    always_comb begin
        occ_nxt = occ;
        case ({push_ok, pop})
            2'b10:   occ_nxt = occ + OCC_W'(1);
            2'b01:   occ_nxt = occ - OCC_W'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (occ != '0) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (hs_collect && last_sub) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (pop) begin
                    state_nxt = (occ_nxt != '0) ? S_COLLECT : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (push_ok) begin
            id_mem[wr_ptr]  <= aw_id;
            cnt_mem[wr_ptr] <= sub_norm;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            sub_ctr   <= '0;
            acc       <= '0;
            resp      <= '0;
            err_unexp <= 1'b0;
        end else begin
            occ <= occ_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_drop || hs_unexp) begin
                err_unexp <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (occ != '0) begin
                        sub_ctr <= '0;
                        acc     <= '0;
                    end
                end
                S_COLLECT: begin
                    if (hs_collect) begin
                        sub_ctr <= sub_inc;
                        acc     <= merged;
                        if (last_sub) begin
                            resp <= pack_resp(head_id, merged);
                        end
                    end
                end
                S_ISSUE: begin
                    // The next head's collection starts from a clean slate.
                    if (pop) begin
                        sub_ctr <= '0;
                        acc     <= '0;
                    end
                end
                default: begin
                    sub_ctr <= '0;
                    acc     <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/b_resp_merge.md
B_RESP_MERGE -- requirements
Module: b_resp_merge

Interface
REQ-001 SHALL have parameter BID_WIDTH, default 3, meaning master-side write ID width.
REQ-002 SHALL have parameter BRESP_WIDTH, default 2, meaning write-response width.
REQ-003 SHALL have parameter SUB_XFER_CNT, default 3, meaning max slave sub-bursts per master burst; CNT_W = clog2(SUB_XFER_CNT+1).
REQ-004 SHALL have parameter RESP_ARR_WIDTH, default 9, meaning packed response word width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning outstanding master AW entries (power of two).
REQ-006 aclk  input  1  sole clock, all state on rising edge.
REQ-007 arst  input  1  synchronous, active-high reset.
REQ-008 aw_push  input  1  master AW accepted this cycle; enqueue {aw_id, aw_sub_cnt}.
REQ-009 aw_id  input  BID_WIDTH  ID of the accepted master burst.
REQ-010 aw_sub_cnt  input  CNT_W  number of slave sub-bursts for this master burst.
REQ-011 aw_ready  output  1  FIFO not full.
REQ-012 s_b_handshake  input  1  slave-side B handshake completed this cycle.
REQ-013 s_bresp  input  BRESP_WIDTH  slave response qualified by s_b_handshake.
REQ-014 rd_ready  input  1  downstream B stage can take a response (driven as !m_bvalid).
REQ-015 rd_valid  output  1  one-cycle pulse: resp holds a merged master response.
REQ-016 resp  output  RESP_ARR_WIDTH  {id[8:6], 3'b000[5:3], bresp[2:1], 1'b1[0]}.
REQ-017 err_unexp  output  1  sticky flag: protocol violation seen.

Function
REQ-018 SHALL hold an AW FIFO of FIFO_DEPTH entries {id, sub_cnt}, with occupancy counter 0..FIFO_DEPTH; aw_ready = (count != FIFO_DEPTH).
REQ-019 SHALL enqueue when aw_push && aw_ready; aw_push while full SHALL be dropped and SHALL set err_unexp.
REQ-020 SHALL treat aw_sub_cnt = 0 as 1, and values above SUB_XFER_CNT as SUB_XFER_CNT.
REQ-021 SHALL implement FSM states IDLE, COLLECT and ISSUE.
REQ-022 IDLE: count != 0 -> COLLECT, clearing the sub-counter and accumulator; a push into an empty FIFO reaches COLLECT one cycle after the push.
REQ-023 COLLECT: on s_b_handshake, increment the sub-counter and merge s_bresp into the accumulator; the first response loads the accumulator directly.
REQ-024 COLLECT: when the incremented sub-counter equals the head sub_cnt, go to ISSUE next cycle with resp registered from head id and the merged bresp.
REQ-025 Merge priority SHALL be DECERR(11) > SLVERR(10) > OKAY(00) > EXOKAY(01): EXOKAY only if every sub-response is EXOKAY.
REQ-026 ISSUE: rd_valid = (state==ISSUE) && rd_ready, combinational, asserted for exactly one cycle per master burst.
REQ-027 ISSUE: when rd_valid is high, pop the head; next state is COLLECT if post-pop count != 0 (including a simultaneous push), otherwise IDLE.
REQ-028 ISSUE with rd_ready low: hold state and resp indefinitely.
REQ-029 s_b_handshake in IDLE or ISSUE SHALL be ignored (not counted) and SHALL set err_unexp.
REQ-030 A simultaneous push and pop SHALL leave count unchanged and be accepted even when full.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 The first rd_valid for a burst SHALL come at the earliest one cycle after the completing s_b_handshake.
REQ-033 resp SHALL hold its last value between pulses.

Reset
REQ-034 With arst high at a clock edge: state IDLE, count 0, pointers 0, sub-counter 0, accumulator 00, resp 0, err_unexp 0; aw_ready reads 1 and rd_valid reads 0.
REQ-035 Reset mid-operation SHALL discard all queued and partial bursts, with no rd_valid in the cycle after reset.

Verification
REQ-036 Push id=5, sub_cnt=3, then three handshakes OKAY,SLVERR,OKAY with rd_ready=1 -> one rd_valid pulse, resp=9'b101_000_10_1.
REQ-037 Push id=2, sub_cnt=2, then responses EXOKAY,EXOKAY -> resp bresp=01; repeat with EXOKAY,OKAY -> bresp=00.
REQ-038 Complete a burst with rd_ready=0 for 5 cycles -> rd_valid stays 0 and resp is stable; raise rd_ready -> exactly one pulse.
REQ-039 Push 4 entries then a 5th -> aw_ready=0 and 5th dropped, err_unexp=1; push and pop in the same cycle while full -> accepted, count stays 4.
REQ-040 s_b_handshake with FIFO empty -> err_unexp=1 and no rd_valid; then assert arst -> err_unexp=0 and aw_ready=1.
REQ-041 Back-to-back bursts id=1 (cnt 1) and id=3 (cnt 2), with pointers wrapped past depth -> pulses in order, ids 1 then 3.
